// File: rtl/jk_pkg.sv
// Shared definitions for the JK-based up/down modulus counter.
package jk_pkg;

    // Default geometry: a 4-bit decade counter.
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

    // Operating mode chosen each cycle, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        CLR   = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } mode_t;

endpackage

// File: rtl/jk_stage.sv
// One JK storage cell holding a single count bit.
module jk_stage (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // Standard JK behaviour: hold, clear, set or toggle; async reset to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulus up/down counter built from JK cells, with clear, load and cascade flag.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    // Largest legal count and the modulus widened so 2^WIDTH still fits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    mode_t            mode;
    logic [WIDTH-1:0] sat_d;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] j_int;
    logic [WIDTH-1:0] k_int;
    logic [WIDTH-1:0] qb_int;

    // Resolve the control inputs into one mode using clr > load > en priority.
    always_comb begin
        mode = HOLD;
        if (clr) begin
            mode = CLR;
        end else if (load) begin
            mode = LOAD;
        end else if (en) begin
            mode = COUNT;
        end
    end

    // Candidate values: saturated load and wrapped steps; out-of-range counts recover.
    always_comb begin
        sat_d   = ({1'b0, d} < MOD_EXT) ? d : MAX_VAL;
        step_up = (q >= MAX_VAL) ? '0 : q + WIDTH'(1);
        step_dn = ((q == '0) || (q > MAX_VAL)) ? MAX_VAL : q - WIDTH'(1);
    end

    // Choose the next count for the current mode; hold keeps q so no bit is excited.
    always_comb begin
        n = q;
        case (mode)
            CLR:     n = '0;
            LOAD:    n = sat_d;
            COUNT:   n = up_dn ? step_up : step_dn;
            default: n = q;
        endcase
    end

    // Per-bit excitation: set bits rising 0->1, clear bits falling 1->0, silent in reset.
    always_comb begin
        j_int = '0;
        k_int = '0;
        if (!rst) begin
            j_int = n & ~q;
            k_int = q & ~n;
        end
    end

    // Terminal count flags the cycle before a wrap so a following stage can count.
    always_comb begin
        tc = 1'b0;
        if (!rst && mode == COUNT) begin
            tc = up_dn ? (q == MAX_VAL) : (q == '0);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .j     (j_int[i]),
            .k     (k_int[i]),
            .q     (q[i]),
            .q_bar (qb_int[i])
        );
    end

    assign q_bar = qb_int;
    assign j_vec = j_int;
    assign k_vec = k_int;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter against an integer reference model.
module tb_jk_updown_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    int total = 0;
    int bad   = 0;
    int model = 0;

    jk_updown_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .up_dn (up_dn),
        .clr   (clr),
        .load  (load),
        .d     (d),
        .q     (q),
        .q_bar (q_bar),
        .tc    (tc),
        .j_vec (j_vec),
        .k_vec (k_vec)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference next count from the priority rules using plain integer arithmetic.
    function automatic int nextCount(int cur, logic c, logic l, logic e, logic u, int dv);
        if (c) return 0;
        if (l) return (dv < MODULUS) ? dv : MODULUS - 1;
        if (e) return u ? (cur + 1) % MODULUS : (cur + MODULUS - 1) % MODULUS;
        return cur;
    endfunction

    // One comparison: counted, and reported with tag/observed/expected on failure.
    task automatic checkValue(string tag, logic [WIDTH-1:0] observed, logic [WIDTH-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with what the model predicts for the current inputs.
    task automatic checkOutput(string tag);
        int               nxt;
        logic             exp_tc;
        logic [WIDTH-1:0] cur_q;
        logic [WIDTH-1:0] nxt_q;
        logic [WIDTH-1:0] exp_j;
        logic [WIDTH-1:0] exp_k;
        nxt    = nextCount(model, clr, load, en, up_dn, int'(d));
        cur_q  = WIDTH'(model);
        nxt_q  = WIDTH'(nxt);
        exp_tc = !rst && en && !clr && !load &&
                 ((up_dn && model == MODULUS - 1) || (!up_dn && model == 0));
        exp_j  = rst ? '0 : (nxt_q & ~cur_q);
        exp_k  = rst ? '0 : (cur_q & ~nxt_q);
        checkValue({tag, ".q"},     q,                  cur_q);
        checkValue({tag, ".q_bar"}, q_bar,              ~cur_q);
        checkValue({tag, ".tc"},    {3'b000, tc},       {3'b000, exp_tc});
        checkValue({tag, ".j"},     j_vec,              exp_j);
        checkValue({tag, ".k"},     k_vec,              exp_k);
        checkValue({tag, ".jk"},    j_vec & k_vec,      4'b0000);
    endtask

    // Drive one cycle of inputs, check before the edge, then advance the model.
    task automatic applyStimulus(logic e, logic u, logic c, logic l, logic [WIDTH-1:0] dv, string tag);
        en    = e;
        up_dn = u;
        clr   = c;
        load  = l;
        d     = dv;
        #1;
        checkOutput(tag);
        @(posedge clk);
        model = nextCount(model, c, l, e, u, int'(dv));
        #1;
    endtask

    initial begin
        // Reset held with inputs that would otherwise excite the counter.
        rst   = 1'b1;
        en    = 1'b1;
        up_dn = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
        d     = '0;
        model = 0;
        #12;
        checkOutput("reset");
        #1;
        rst = 1'b0;

        // Count up across the wrap: 1..9, 0, 1, 2.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up");
        end
        checkValue("up_end", q, 4'd2);

        // Clear, then count down from 0 to wrap to 9.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "clr");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "down_wrap");
        checkValue("down_wrap_q", q, 4'd9);

        // Loads: out-of-range saturates, in-range passes, clear beats load.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, "load13");
        checkValue("load13_q", q, 4'd9);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, "load6");
        checkValue("load6_q", q, 4'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd6, "clr_load");
        checkValue("clr_load_q", q, 4'd0);

        // Hold at 5.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, "load5");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "hold1");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "hold2");
        checkValue("hold_q", q, 4'd5);

        // 7 -> 8 excitation pattern.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, "load7");
        en    = 1'b1;
        up_dn = 1'b1;
        load  = 1'b0;
        #1;
        checkValue("j_7to8", j_vec, 4'b1000);
        checkValue("k_7to8", k_vec, 4'b0111);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "step7to8");
        checkValue("q_8", q, 4'd8);

        // Asynchronous reset pulse between edges at q=7.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, "reload7");
        en    = 1'b1;
        up_dn = 1'b1;
        load  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkValue("async_rst_q", q, 4'd0);
        model = 0;
        checkOutput("rst_pulse");
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "restart");
        checkValue("restart_q", q, 4'd1);

        // Randomized mix of all controls, with direction changing freely.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)),
                          "rand");
        end
        checkOutput("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
